// File: rtl/tone_voice.sv
`default_nettype none
// ============================================================================
// Module   : tone_voice
// Brief    : Single-voice tone generator with gated attack/sustain/release
//            envelope and PWM volume driving the amplifier pins.
// Revision : 1.0 - initial release
// ============================================================================
module tone_voice #(
  parameter int   OCT_MAX   = 5,
  parameter int   OCT_SHIFT = 8,
  parameter int   VOL_W     = 4,
  parameter int   ENV_STEP  = 65536,
  parameter logic LOW_GAIN  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             note_valid,
  output logic             note_ready,
  input  logic [6:0]       note_code,
  input  logic             key_on,
  input  logic [VOL_W-1:0] volume,
  output logic             err,
  output logic [VOL_W-1:0] env_level,
  output logic             AIN,
  output logic             GAIN,
  output logic             NC,
  output logic             ACTIVE
);

  localparam int ENV_W   = $clog2(ENV_STEP);
  localparam int N_CODES = 12 * (OCT_MAX + 1);
  localparam logic [OCT_SHIFT-1:0] C_OCT_ALL = {OCT_SHIFT{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ATTACK  = 2'd1,
    S_SUSTAIN = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [VOL_W-1:0]     level_q, level_d;
  logic [ENV_W-1:0]     env_cnt_q, env_cnt_d;
  logic [VOL_W-1:0]     pwm_cnt_q;
  logic [6:0]           code_q;
  logic [8:0]           note_cnt_q, note_cnt_d;
  logic [OCT_SHIFT-1:0] oct_cnt_q, oct_cnt_d;
  logic                 speaker_q, speaker_d;
  logic                 ain_q, active_q, err_q;
  logic                 w_tick, w_accept, w_code_ok, w_load;

  // Half-period of the lowest-octave note, minus one.
  function automatic logic [8:0] base_of(input logic [6:0] code);
    logic [6:0] n;
    n = code % 7'd12;
    case (n)
      7'd0:    return 9'd511;
      7'd1:    return 9'd482;
      7'd2:    return 9'd455;
      7'd3:    return 9'd430;
      7'd4:    return 9'd405;
      7'd5:    return 9'd383;
      7'd6:    return 9'd361;
      7'd7:    return 9'd341;
      7'd8:    return 9'd322;
      7'd9:    return 9'd303;
      7'd10:   return 9'd286;
      default: return 9'd270;
    endcase
  endfunction

  // 2^(OCT_SHIFT-octave)-1 as a right shift of an all-ones word.
  function automatic logic [OCT_SHIFT-1:0] orel_of(input logic [6:0] code);
    return C_OCT_ALL >> (code / 7'd12);
  endfunction

  assign note_ready = !rst && (state_q != S_RELEASE);
  assign w_accept   = note_valid && note_ready;
  assign w_code_ok  = {1'b0, note_code} < 8'(N_CODES);
  assign w_load     = w_accept && w_code_ok;
  assign w_tick     = (env_cnt_q == ENV_W'(ENV_STEP - 1));
  assign env_cnt_d  = w_tick ? '0 : env_cnt_q + ENV_W'(1);

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    case (state_q)
      S_IDLE: begin
        if (key_on) state_d = S_ATTACK;
      end
      S_ATTACK: begin
        if (!key_on) begin
          state_d = S_RELEASE;
        end else if (level_q >= volume) begin
          state_d = S_SUSTAIN;
        end else if (w_tick) begin
          level_d = level_q + VOL_W'(1);
          if (level_d >= volume) state_d = S_SUSTAIN;
        end
      end
      S_SUSTAIN: begin
        if (!key_on) state_d = S_RELEASE;
        else         level_d = volume;
      end
      S_RELEASE: begin
        if (key_on) begin
          state_d = S_ATTACK;
        end else if (level_q == '0) begin
          state_d = S_IDLE;
        end else if (w_tick) begin
          level_d = level_q - VOL_W'(1);
          if (level_d == '0) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pitch divider: note counter feeds the octave counter; speaker flips when both wrap.
  always_comb begin
    note_cnt_d = note_cnt_q;
    oct_cnt_d  = oct_cnt_q;
    speaker_d  = speaker_q;
    if (state_q == S_IDLE) begin
      note_cnt_d = '0;
      oct_cnt_d  = '0;
      speaker_d  = 1'b0;
    end else if (w_load) begin
      note_cnt_d = base_of(note_code);
      oct_cnt_d  = orel_of(note_code);
    end else if (note_cnt_q == '0) begin
      note_cnt_d = base_of(code_q);
      if (oct_cnt_q == '0) begin
        oct_cnt_d = orel_of(code_q);
        speaker_d = ~speaker_q;
      end else begin
        oct_cnt_d = oct_cnt_q - OCT_SHIFT'(1);
      end
    end else begin
      note_cnt_d = note_cnt_q - 9'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      level_q    <= '0;
      env_cnt_q  <= '0;
      pwm_cnt_q  <= '0;
      code_q     <= '0;
      note_cnt_q <= '0;
      oct_cnt_q  <= '0;
      speaker_q  <= 1'b0;
      ain_q      <= 1'b0;
      active_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      env_cnt_q  <= env_cnt_d;
      pwm_cnt_q  <= pwm_cnt_q + VOL_W'(1);
      if (w_load) code_q <= note_code;
      note_cnt_q <= note_cnt_d;
      oct_cnt_q  <= oct_cnt_d;
      speaker_q  <= speaker_d;
      ain_q      <= speaker_q && (pwm_cnt_q < level_q);
      active_q   <= (state_q != S_IDLE);
      err_q      <= w_accept && !w_code_ok;
    end
  end

  assign env_level = level_q;
  assign err       = err_q;
  assign AIN       = ain_q;
  assign ACTIVE    = active_q;
  assign GAIN      = LOW_GAIN;
  assign NC        = 1'b0;

endmodule
`default_nettype wire

// File: doc/tone_voice.md
Name: tone_voice

Overview:
Parametrised single-voice tone generator with a gated attack/sustain/release envelope and PWM volume. It drives the same amplifier pins (AIN, GAIN, NC, ACTIVE) as the free-running tone/amplifier block. Unlike that block, pitch comes from a valid/ready note interface, gating comes from a key input, and loudness is set by a programmable level rather than a fixed 1/64 duty.

Parameters:
OCT_MAX, 5, highest octave index; valid note codes are 0 .. 12*(OCT_MAX+1)-1.
OCT_SHIFT, 8, octave-0 multiplier exponent; octave o multiplies the half-period by 2^(OCT_SHIFT-o). Must be >= OCT_MAX.
VOL_W, 4, width of volume, envelope level and PWM counter.
ENV_STEP, 65536, clocks per envelope step (>= 2).
LOW_GAIN, 1, constant value driven on GAIN.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
note_valid  in  1  note_code is valid
note_ready  out  1  voice accepts a note this cycle
note_code  in  7  note code; octave = code/12, note = code%12 (0=A .. 11=G#)
key_on  in  1  gate: high holds the note, low releases it
volume  in  VOL_W  sustain target level
err  out  1  one-cycle pulse when an out-of-range code is accepted
env_level  out  VOL_W  current envelope level
AIN  out  1  amplifier audio input
GAIN  out  1  amplifier gain select
NC  out  1  tied 0
ACTIVE  out  1  amplifier enable

Behaviour:
- Reset: state=IDLE, env_level=0, stored code=0, speaker=0, AIN=0, ACTIVE=0, err=0, all counters=0. note_ready=0 while rst is high.
- Handshake: note_ready = !rst && state!=RELEASE. A note is accepted when note_valid && note_ready.
- Accepted code >= 12*(OCT_MAX+1): stored pitch is unchanged; err=1 on the next cycle only.
- Accepted valid code: stored code updates. Both pitch counters reload on the next cycle (phase restart). speaker keeps its value.
- Base reload values by note, 0..11: 511, 482, 455, 430, 405, 383, 361, 341, 322, 303, 286, 270.
- note counter: 9 bits, counts down from the base reload; at 0 it reloads.
- octave counter: OCT_SHIFT bits; decrements on each note-counter zero; at 0 it reloads 2^(OCT_SHIFT-octave)-1.
- speaker toggles when both counters are 0. Resulting half-period = (base+1)*2^(OCT_SHIFT-octave) clocks.
- In IDLE, pitch counters and speaker are held at 0.
- env_tick: free-running prescaler 0..ENV_STEP-1; tick when it equals ENV_STEP-1. It is not reset by state changes.
- FSM:
  - IDLE -> ATTACK when key_on=1. A same-cycle accepted note is used.
  - ATTACK: on tick, env_level += 1. -> SUSTAIN when env_level >= volume.
  - SUSTAIN: env_level = volume each cycle, so volume changes track immediately.
  - ATTACK/SUSTAIN -> RELEASE when key_on=0. This has priority over ATTACK->SUSTAIN.
  - RELEASE: on tick, env_level -= 1. -> IDLE on the tick that makes env_level 0, or immediately if env_level is already 0.
  - RELEASE -> ATTACK when key_on=1 (retrigger). Level continues from its current value, no restart at 0.
  - volume=0 in ATTACK: go straight to SUSTAIN.
- PWM: pwm_cnt, VOL_W bits, free-running wrap. pwm_on = pwm_cnt < env_level.
- AIN is registered: speaker & pwm_on, one cycle latency. env_level=0 gives a silent output.
- ACTIVE is registered: state!=IDLE.
- GAIN=LOW_GAIN, NC=0, both constant.
- rst mid-operation: everything returns to reset values on the next edge, regardless of state.

Test Plan:
- ENV_STEP=4, volume=3: accept code 60, hold key_on=1 -> env_level goes 1,2,3 on successive ticks. SUSTAIN after the 3rd tick. ACTIVE=1 one cycle after leaving IDLE.
- SUSTAIN, code 60 (A, octave 5) -> speaker half-period is 512*8=4096 clocks. Then accept code 63 -> counters restart, half-period becomes 431*8=3448 clocks.
- Drop key_on in SUSTAIN at level 3 -> env_level steps 2,1,0 on ticks. Then IDLE, ACTIVE=0 one cycle later, AIN=0, note_ready low throughout RELEASE.
- Accept code 72 with OCT_MAX=5 -> err pulses for exactly 1 cycle, pitch unchanged. Code 71 is accepted without err.
- key_on back to 1 in RELEASE at level 2 -> state ATTACK, next tick gives level 3. Also: volume 15->5 in SUSTAIN -> env_level=5 the next cycle.
- Assert rst for 1 cycle in RELEASE -> all outputs at reset values the next cycle. note_ready returns the cycle after rst falls.
